uart_tx_serializer: RTL
=======================

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter STOP2_EN, default 1: when 0, the 2-stop-bit mode is disabled and stop2 is ignored.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 tick  input  1  baud enable, one-clk pulse per bit period.
REQ-006 data_in  input  DATA_W  frame payload.
REQ-007 valid  input  1  payload/config offered.
REQ-008 parity_type  input  2  00 none, 01 odd, 10 even, 11 none.
REQ-009 stop2  input  1  1 = two stop bits (only when STOP2_EN=1).
REQ-010 ready  output  1  block can accept a frame.
REQ-011 tx  output  1  serial line, idle high.
REQ-012 parity_bit  output  1  parity of the latched frame.
REQ-013 busy  output  1  frame in progress.
REQ-014 done  output  1  one-clk pulse at frame end.

Function
REQ-015 States: IDLE, LOAD, START, DATA, PARITY, STOP; all outputs registered.
REQ-016 ready=1 only in IDLE; a transfer occurs on a rising edge with valid&&ready, latching data_in, parity_type and stop2; the FSM then enters LOAD.
REQ-017 Inputs changing after acceptance have no effect on the current frame; valid while ready=0 is ignored, with no queuing.
REQ-018 LOAD: tx=1; on the first edge with tick=1, go to START, so every bit spans exactly one full tick period.
REQ-019 Each of START/DATA/PARITY/STOP advances only on an edge with tick=1; tick in IDLE is ignored.
REQ-020 START: tx=0 for 1 bit period.
REQ-021 DATA: tx=data bit, LSB first, for DATA_W bit periods, tracked by a bit counter of width clog2(DATA_W+1).
REQ-022 PARITY (only for parity_type 01/10): even parity = XOR of the latched data; odd parity = its inverse; tx=parity for 1 bit period.
REQ-023 For parity_type 00/11, DATA goes directly to STOP.
REQ-024 STOP: tx=1 for 1 bit period, or 2 bit periods if the latched stop2=1 and STOP2_EN=1.
REQ-025 On the tick edge ending the last stop bit: done=1 for that one cycle, FSM goes to IDLE, and ready=1 in the same cycle.
REQ-026 Back-to-back operation: valid held high is accepted on the edge after done, and the next frame's LOAD follows with no extra idle cycle.
REQ-027 busy=1 in all states except IDLE.
REQ-028 parity_bit holds the computed parity from acceptance until IDLE, is 0 in IDLE, and is 0 for parity_type 00/11.
REQ-029 tx=1 in IDLE and LOAD.

Reset
REQ-030 On rst assertion, immediately and independent of clk: state=IDLE, tx=1, ready=1, busy=0, done=0, parity_bit=0, bit counter=0, latched registers=0.
REQ-031 Reset mid-frame aborts the frame without a done pulse; tx returns high in the same cycle.
REQ-032 After rst deassertion, the first acceptance may occur on the next rising edge with valid=1.

Verification
REQ-033 DATA_W=8, data_in=8'hA5, parity 10, stop2=0, tick every 4 clk -> tx bit periods 0,1,0,1,0,0,1,0,1,0,1; parity_bit=0; one done pulse; 44 clk from the first tick after acceptance to done.
REQ-034 data_in=8'h01, parity 01, stop2=1 -> parity bit=0, two stop periods high, busy=1 throughout, done pulses once.
REQ-035 parity 00, DATA_W=7, data 7'h55 -> no parity period; frame = start + 7 data + 1 stop = 9 bit periods.
REQ-036 valid held high with two consecutive payloads -> second accepted on the edge after the first done; no gap beyond LOAD alignment to tick.
REQ-037 rst asserted during DATA bit 3 -> tx=1, busy=0, ready=1 without waiting for a clk edge; no done pulse; the next frame transmits correctly.
REQ-038 data_in/parity_type toggled during DATA -> transmitted bits match the values latched at acceptance.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// ------------------
// Frame serializer for an asynchronous serial transmitter. A payload offered
// with valid while ready is high is latched together with its parity mode and
// stop-bit selection, then shifted out on tx as
//   start(0), DATA_W data bits LSB first, optional parity, one or two stop(1)
// with every bit lasting one period of the external baud enable 'tick'.
//
// Parameters
//   DATA_W      data bits per frame (5..9)
//   STOP2_EN    1 allows the two-stop-bit mode, 0 forces a single stop bit
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-high reset
//   tick         in   one-clk baud enable pulse per bit period
//   data_in      in   frame payload
//   valid        in   payload and configuration offered
//   parity_type  in   00 none, 01 odd, 10 even, 11 none
//   stop2        in   request two stop bits
//   ready        out  block can accept a frame (IDLE only)
//   tx           out  serial line, idle high
//   parity_bit   out  parity of the frame in flight, 0 when idle or no parity
//   busy         out  frame in progress
//   done         out  one-clk pulse on the edge that ends the last stop bit
//
// All outputs come straight from flops; the next-state logic computes the
// value each output should take after the coming edge.

module uart_tx_serializer #(
  parameter int DATA_W   = 8,
  parameter int STOP2_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  input  logic [1:0]        parity_type,
  input  logic              stop2,
  output logic              ready,
  output logic              tx,
  output logic              parity_bit,
  output logic              busy,
  output logic              done
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);
  localparam bit                STOP2_OK = (STOP2_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              parEn_q, parEn_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              par_q, par_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              parReq;
  logic              parCalc;

  // A transfer happens only while the registered ready is high, so a valid
  // seen mid-frame is simply dropped rather than queued.
  assign accept = valid && ready_q;

  // Parity is resolved from the raw inputs at the accepting edge; after that
  // the frame depends only on latched state.
  assign parReq  = (parity_type == 2'b01) || (parity_type == 2'b10);
  assign parCalc = (parity_type == 2'b01) ? ~(^data_in) : (^data_in);

  // Next-state and next-output logic. The bit counter holds the number of
  // data bits already placed on the line; in STOP it marks whether the first
  // of two stop bits has elapsed.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    parEn_d = parEn_q;
    stop2_d = stop2_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    par_d   = par_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
          shift_d = data_in;
          cnt_d   = '0;
          parEn_d = parReq;
          stop2_d = stop2 && STOP2_OK;
          par_d   = parReq ? parCalc : 1'b0;
          tx_d    = 1'b1;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      // Waiting here for the first tick keeps the start bit a full period
      // long regardless of where acceptance fell within the baud period.
      LOAD: begin
        if (tick) begin
          state_d = START;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = CNT_W'(1);
        end
      end

      DATA: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (parEn_q) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end

      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
          cnt_d   = '0;
        end
      end

      STOP: begin
        if (tick) begin
          if (stop2_q && (cnt_q == '0)) begin
            cnt_d = CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            tx_d    = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            par_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        par_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the line high and aborts any
  // frame without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      parEn_q <= 1'b0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      par_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      parEn_q <= parEn_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      par_q   <= par_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready      = ready_q;
  assign tx         = tx_q;
  assign parity_bit = par_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
